fetch_unit: RTL and testbench

Instruction fetch stage for the single-cycle lab core. It holds the program counter and reads the word-addressed instruction memory through a combinational read port. Each fetched instruction is delivered, together with its PC, to the decode/register-file stage through a 2-entry valid/ready buffer. Taken branches and jumps are serviced via a redirect input that flushes the buffer.

---
 rtl/fetch_unit.sv | 87 ++++++++
 tb/tb_fetch_unit.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: PC register, combinational imem read, and a 2-entry
// {pc, inst} buffer toward decode with redirect-driven flush.
module fetch_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int IMEM_DEPTH = 256,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  output logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
  input  logic [31:0]                   imem_rdata,
  input  logic                          redirect_valid,
  input  logic [ADDR_WIDTH-1:0]         redirect_pc,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [31:0]                   out_inst,
  output logic [ADDR_WIDTH-1:0]         out_pc,
  output logic                          misalign_err
);

  localparam int IW = $clog2(IMEM_DEPTH);

  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] slot_pc [2];
  logic [31:0]           slot_inst [2];
  logic                  rd_ptr;
  logic                  wr_ptr;
  logic [1:0]            count;
  logic                  pop;
  logic                  push;

  // Memory index uses only low PC bits, so high PCs alias.
  assign imem_addr = pc[IW+1:2];

  assign out_valid = (count != 2'd0);
  assign out_inst  = slot_inst[rd_ptr];
  assign out_pc    = slot_pc[rd_ptr];

  assign pop  = out_valid && out_ready;
  assign push = !redirect_valid && ((count < 2'd2) || pop);

  // PC, pointers, occupancy and sticky misalignment flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc           <= RESET_PC;
      rd_ptr       <= 1'b0;
      wr_ptr       <= 1'b0;
      count        <= 2'd0;
      misalign_err <= 1'b0;
    end else if (redirect_valid) begin
      pc     <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
      if (redirect_pc[1:0] != 2'b00) begin
        misalign_err <= 1'b1;
      end
    end else begin
      if (push) begin
        pc     <= pc + ADDR_WIDTH'(4);
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Buffer slot storage; written only on an accepted push.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_pc[0]   <= '0;
      slot_pc[1]   <= '0;
      slot_inst[0] <= '0;
      slot_inst[1] <= '0;
    end else if (push) begin
      slot_pc[wr_ptr]   <= pc;
      slot_inst[wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed tests for fetch_unit, including a
// 4-word-memory instance for address aliasing.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_ready;

  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        misalign_err;

  logic [1:0]  imem_addr4;
  logic [31:0] imem_rdata4;
  logic        out_valid4;
  logic [31:0] out_inst4;
  logic [31:0] out_pc4;
  logic        misalign_err4;

  logic [31:0] mem  [256];
  logic [31:0] mem4 [4];

  int tests;
  int fails;

  assign imem_rdata  = mem[imem_addr];
  assign imem_rdata4 = mem4[imem_addr4];

  fetch_unit #(
    .ADDR_WIDTH(32), .IMEM_DEPTH(256), .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .reset(reset),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc(out_pc),
    .misalign_err(misalign_err)
  );

  fetch_unit #(
    .ADDR_WIDTH(32), .IMEM_DEPTH(4), .RESET_PC(32'h0)
  ) dut4 (
    .clk(clk), .reset(reset),
    .imem_addr(imem_addr4), .imem_rdata(imem_rdata4),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid4), .out_ready(out_ready),
    .out_inst(out_inst4), .out_pc(out_pc4),
    .misalign_err(misalign_err4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    out_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    #1;
    tests++;
    if ({out_valid, out_pc, out_inst, misalign_err} !== 66'h0) begin
      fails++;
      $display("FAIL reset_outputs: got v=%b pc=%h inst=%h me=%b required all zero",
               out_valid, out_pc, out_inst, misalign_err);
    end
    tests++;
    if (imem_addr !== 8'd0) begin
      fails++;
      $display("FAIL reset_imem_addr: got %0d required 0", imem_addr);
    end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_seq_fetch;
    logic [31:0] exp_inst [4];
    exp_inst[0] = 32'h00500093;
    exp_inst[1] = 32'h00100113;
    exp_inst[2] = 32'h002081B3;
    exp_inst[3] = 32'h00000063;
    out_ready = 1'b1;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++;
      if ({out_valid, out_pc, out_inst} !==
          {1'b1, 32'(4 * i), exp_inst[i]}) begin
        fails++;
        $display("FAIL seq_fetch[%0d]: got v=%b pc=%h inst=%h required v=1 pc=%h inst=%h",
                 i, out_valid, out_pc, out_inst, 32'(4 * i), exp_inst[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    apply_reset();
    for (int i = 1; i <= 5; i++) begin
      tick();
      tests++;
      if ({out_valid, out_pc, out_inst} !== {1'b1, 32'h0, 32'h00500093}) begin
        fails++;
        $display("FAIL bp_head[%0d]: got v=%b pc=%h inst=%h required v=1 pc=0 inst=00500093",
                 i, out_valid, out_pc, out_inst);
      end
      if (i >= 2) begin
        tests++;
        if ({imem_addr, dut.count} !== {8'd2, 2'd2}) begin
          fails++;
          $display("FAIL bp_full[%0d]: got addr=%0d count=%0d required addr=2 count=2",
                   i, imem_addr, dut.count);
        end
      end
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if ({out_valid, out_pc, out_inst} !==
          {1'b1, 32'(4 * i), mem[i]}) begin
        fails++;
        $display("FAIL bp_drain[%0d]: got v=%b pc=%h inst=%h required v=1 pc=%h inst=%h",
                 i, out_valid, out_pc, out_inst, 32'(4 * i), mem[i]);
      end
      tick();
    end
  endtask

  task automatic test_redirect_full;
    out_ready = 1'b0;
    apply_reset();
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h20;
    tick();
    redirect_valid = 1'b0;
    tests++;
    if ({out_valid, imem_addr} !== {1'b0, 8'd8}) begin
      fails++;
      $display("FAIL redir_bubble: got v=%b addr=%0d required v=0 addr=8",
               out_valid, imem_addr);
    end
    tick();
    tests++;
    if ({out_valid, out_pc, out_inst} !== {1'b1, 32'h20, mem[8]}) begin
      fails++;
      $display("FAIL redir_target: got v=%b pc=%h inst=%h required v=1 pc=20 inst=%h",
               out_valid, out_pc, out_inst, mem[8]);
    end
    out_ready = 1'b1;
    tick();
    tests++;
    if ({out_valid, out_pc} !== {1'b1, 32'h24}) begin
      fails++;
      $display("FAIL redir_next: got v=%b pc=%h required v=1 pc=24",
               out_valid, out_pc);
    end
  endtask

  task automatic test_misalign;
    out_ready = 1'b1;
    apply_reset();
    tick();
    tests++;
    if (misalign_err !== 1'b0) begin
      fails++;
      $display("FAIL misalign_pre: got %b required 0", misalign_err);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h13;
    tick();
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    tests++;
    if ({out_valid, misalign_err} !== 2'b01) begin
      fails++;
      $display("FAIL misalign_set: got v=%b me=%b required v=0 me=1",
               out_valid, misalign_err);
    end
    tick();
    tests++;
    if ({out_valid, out_pc, out_inst} !== {1'b1, 32'h10, mem[4]}) begin
      fails++;
      $display("FAIL misalign_head: got v=%b pc=%h inst=%h required v=1 pc=10 inst=%h",
               out_valid, out_pc, out_inst, mem[4]);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (misalign_err !== 1'b1) begin
        fails++;
        $display("FAIL misalign_sticky[%0d]: got %b required 1", i, misalign_err);
      end
    end
    reset = 1'b1;
    #1;
    tests++;
    if (misalign_err !== 1'b0) begin
      fails++;
      $display("FAIL misalign_clear: got %b required 0", misalign_err);
    end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_wrap;
    logic [1:0]  exp_addr [3];
    logic [31:0] exp_pc [3];
    exp_addr[0] = 2'd3;
    exp_addr[1] = 2'd0;
    exp_addr[2] = 2'd1;
    exp_pc[0] = 32'hC;
    exp_pc[1] = 32'h10;
    exp_pc[2] = 32'h14;
    out_ready = 1'b1;
    apply_reset();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'hC;
    tick();
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (imem_addr4 !== exp_addr[i]) begin
        fails++;
        $display("FAIL wrap_addr[%0d]: got %0d required %0d",
                 i, imem_addr4, exp_addr[i]);
      end
      tick();
      tests++;
      if ({out_valid4, out_pc4, out_inst4} !==
          {1'b1, exp_pc[i], mem4[exp_addr[i]]}) begin
        fails++;
        $display("FAIL wrap_head[%0d]: got v=%b pc=%h inst=%h required v=1 pc=%h inst=%h",
                 i, out_valid4, out_pc4, out_inst4, exp_pc[i], mem4[exp_addr[i]]);
      end
    end
  endtask

  task automatic test_async_reset;
    out_ready = 1'b0;
    apply_reset();
    tick();
    tick();
    tests++;
    if ({out_valid, dut.count, imem_addr} !== {1'b1, 2'd2, 8'd2}) begin
      fails++;
      $display("FAIL async_prefill: got v=%b count=%0d addr=%0d required v=1 count=2 addr=2",
               out_valid, dut.count, imem_addr);
    end
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if ({out_valid, imem_addr, out_pc, out_inst} !== 73'h0) begin
      fails++;
      $display("FAIL async_reset: got v=%b addr=%0d pc=%h inst=%h required all zero",
               out_valid, imem_addr, out_pc, out_inst);
    end
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    tick();
    tests++;
    if ({out_valid, out_pc, out_inst} !== {1'b1, 32'h0, 32'h00500093}) begin
      fails++;
      $display("FAIL async_restart: got v=%b pc=%h inst=%h required v=1 pc=0 inst=00500093",
               out_valid, out_pc, out_inst);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    mem[0] = 32'h00500093;
    mem[1] = 32'h00100113;
    mem[2] = 32'h002081B3;
    mem[3] = 32'h00000063;
    for (int i = 4; i < 256; i++) mem[i] = 32'hA000_0000 + 32'(i);
    for (int i = 0; i < 4; i++) mem4[i] = 32'hB000_0000 + 32'(i);
    test_reset();
    test_seq_fetch();
    test_backpressure();
    test_redirect_full();
    test_misalign();
    test_wrap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
